// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: bus widths, the max-pool
// FSM state encoding and the signed int8 max helper.
package cnn_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RD3  = 3'd4,
    S_WAIT = 3'd5,
    S_WR   = 3'd6,
    S_DONE = 3'd7
  } state_t;

  // Signed int8 maximum; on a tie the current value is kept.
  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] cur,
                                              input logic [DATA_W-1:0] cand);
    return ($signed(cand) > $signed(cur)) ? cand : cur;
  endfunction

endpackage

// File: rtl/maxpool_engine_if.sv
// RAM port bundle between the max-pool engine and the feature-map memory.
//
// Protocol: there is no backpressure. The read port is a fixed-latency
// request: when ram_en_r is high in cycle N, ram_data_r carries the byte at
// ram_addr_r during cycle N+1. A write happens in every cycle where
// ram_en and ram_wea are both high, using ram_addr_w / ram_data_w.
interface maxpool_engine_if;
  import cnn_pkg::*;

  logic [ADDR_W-1:0] ram_addr_r;
  logic              ram_en_r;
  logic [DATA_W-1:0] ram_data_r;
  logic [ADDR_W-1:0] ram_addr_w;
  logic [DATA_W-1:0] ram_data_w;
  logic              ram_en;
  logic              ram_wea;

  modport master (
    output ram_addr_r, ram_en_r, ram_addr_w, ram_data_w, ram_en, ram_wea,
    input  ram_data_r
  );

  modport slave (
    input  ram_addr_r, ram_en_r, ram_addr_w, ram_data_w, ram_en, ram_wea,
    output ram_data_r
  );

endinterface

// File: rtl/mp_addr_gen.sv
// Output-pixel counters (ox, oy, c) and the read/write address arithmetic
// for the 2x2 stride-2 max-pool pass. All addresses wrap modulo 2^16.
module mp_addr_gen
  import cnn_pkg::*;
#(
  parameter int                IN_W     = 28,
  parameter int                IN_H     = 28,
  parameter int                CH       = 6,
  parameter logic [ADDR_W-1:0] IN_BASE  = 16'h0000,
  parameter logic [ADDR_W-1:0] OUT_BASE = 16'h8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,      // restart counters at pixel 0
  input  logic              adv,      // step to the next output pixel
  input  logic [1:0]        quad,     // {dy, dx} within the 2x2 window
  output logic              last,     // current pixel is the final one
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int          OW        = IN_W / 2;
  localparam int          OH        = IN_H / 2;
  localparam int unsigned PLANE_IN  = IN_W * IN_H;
  localparam int unsigned PLANE_OUT = OW * OH;
  localparam logic [7:0]  OW_M1     = 8'(OW - 1);
  localparam logic [7:0]  OH_M1     = 8'(OH - 1);
  localparam logic [7:0]  CH_M1     = 8'(CH - 1);

  logic [7:0] ox_q, ox_d, oy_q, oy_d, c_q, c_d;
  logic [7:0] nx_ox, nx_oy, nx_c;
  logic [7:0] sel_ox, sel_oy, sel_c;

  assign last = (ox_q == OW_M1) && (oy_q == OH_M1) && (c_q == CH_M1);

  // Next pixel in x-then-y-then-channel order, wrapping to 0 after the last.
  always_comb begin
    nx_ox = ox_q + 8'd1;
    nx_oy = oy_q;
    nx_c  = c_q;
    if (ox_q == OW_M1) begin
      nx_ox = '0;
      if (oy_q == OH_M1) begin
        nx_oy = '0;
        nx_c  = (c_q == CH_M1) ? '0 : c_q + 8'd1;
      end else begin
        nx_oy = oy_q + 8'd1;
      end
    end
  end

  // Counter update: clear on a new pass, step when the engine finishes a pixel.
  always_comb begin
    ox_d = ox_q;
    oy_d = oy_q;
    c_d  = c_q;
    if (clr) begin
      ox_d = '0;
      oy_d = '0;
      c_d  = '0;
    end else if (adv) begin
      ox_d = nx_ox;
      oy_d = nx_oy;
      c_d  = nx_c;
    end
  end

  // Read address looks ahead to the next pixel while stepping, so the first
  // read of a pixel can be issued in the same cycle the counters move.
  always_comb begin
    sel_ox  = adv ? nx_ox : ox_q;
    sel_oy  = adv ? nx_oy : oy_q;
    sel_c   = adv ? nx_c  : c_q;
    rd_addr = IN_BASE
            + 16'(32'(sel_c) * PLANE_IN)
            + 16'((32'({sel_oy, 1'b0}) + 32'(quad[1])) * 32'(IN_W))
            + 16'(32'({sel_ox, 1'b0}) + 32'(quad[0]));
    wr_addr = OUT_BASE
            + 16'(32'(c_q) * PLANE_OUT)
            + 16'(32'(oy_q) * 32'(OW))
            + 16'(32'(ox_q));
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ox_q <= '0;
      oy_q <= '0;
      c_q  <= '0;
    end else begin
      ox_q <= ox_d;
      oy_q <= oy_d;
      c_q  <= c_d;
    end
  end

endmodule

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 max-pool engine over a channel-major int8 feature map.
// Each output pixel takes six cycles: four reads, one drain cycle for the
// last read's data, one write. All outputs are registered.
module maxpool_engine
  import cnn_pkg::*;
#(
  parameter int                IN_W     = 28,
  parameter int                IN_H     = 28,
  parameter int                CH       = 6,
  parameter logic [ADDR_W-1:0] IN_BASE  = 16'h0000,
  parameter logic [ADDR_W-1:0] OUT_BASE = 16'h8000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  maxpool_engine_if.master   ram,
  output logic               busy,
  output logic               end_flag,
  output state_t             dbg_state
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [ADDR_W-1:0] addr_r_q, addr_r_d;
  logic              en_r_q, en_r_d;
  logic [ADDR_W-1:0] addr_w_q, addr_w_d;
  logic [DATA_W-1:0] data_w_q, data_w_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              end_q, end_d;

  logic              clr, adv, last;
  logic [1:0]        quad;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  assign clr = (state_q == S_IDLE) && start;
  assign adv = (state_q == S_WR);

  mp_addr_gen #(
    .IN_W    (IN_W),
    .IN_H    (IN_H),
    .CH      (CH),
    .IN_BASE (IN_BASE),
    .OUT_BASE(OUT_BASE)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .adv    (adv),
    .quad   (quad),
    .last   (last),
    .rd_addr(rd_addr),
    .wr_addr(wr_addr)
  );

  // State sequencing and running max; data for read N arrives one state later.
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    data_w_d = data_w_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RD0;
      S_RD0:  state_d = S_RD1;
      S_RD1: begin
        max_d   = ram.ram_data_r;
        state_d = S_RD2;
      end
      S_RD2: begin
        max_d   = smax(max_q, ram.ram_data_r);
        state_d = S_RD3;
      end
      S_RD3: begin
        max_d   = smax(max_q, ram.ram_data_r);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        max_d    = smax(max_q, ram.ram_data_r);
        data_w_d = max_d;
        state_d  = S_WR;
      end
      S_WR:   state_d = last ? S_DONE : S_RD0;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every strobe is a flop output.
  always_comb begin
    case (state_d)
      S_RD1:   quad = 2'd1;
      S_RD2:   quad = 2'd2;
      S_RD3:   quad = 2'd3;
      default: quad = 2'd0;
    endcase
    en_r_d   = (state_d == S_RD0) || (state_d == S_RD1) ||
               (state_d == S_RD2) || (state_d == S_RD3);
    addr_r_d = en_r_d ? rd_addr : addr_r_q;
    wr_d     = (state_d == S_WR);
    addr_w_d = wr_d ? wr_addr : addr_w_q;
    busy_d   = (state_d != S_IDLE);
    end_d    = (state_d == S_DONE);
  end

  // FSM and output registers; reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      max_q    <= '0;
      addr_r_q <= '0;
      en_r_q   <= 1'b0;
      addr_w_q <= '0;
      data_w_q <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      addr_r_q <= addr_r_d;
      en_r_q   <= en_r_d;
      addr_w_q <= addr_w_d;
      data_w_q <= data_w_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      end_q    <= end_d;
    end
  end

  assign ram.ram_addr_r = addr_r_q;
  assign ram.ram_en_r   = en_r_q;
  assign ram.ram_addr_w = addr_w_q;
  assign ram.ram_data_w = data_w_q;
  assign ram.ram_en     = wr_q;
  assign ram.ram_wea    = wr_q;
  assign busy           = busy_q;
  assign end_flag       = end_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_maxpool_engine.sv
// Bench for maxpool_engine: five parameterisations share one byte-array RAM
// model; each pass is checked against a reference max-pool computed directly
// from the feature-map layout.
module tb_maxpool_engine;
  import cnn_pkg::*;

  localparam int NI = 5;

  function automatic int cfg_w(input int g);
    case (g)
      0: return 4;
      1: return 2;
      2: return 5;
      3: return 4;
      default: return 28;
    endcase
  endfunction

  function automatic int cfg_ch(input int g);
    case (g)
      3: return 2;
      4: return 6;
      default: return 1;
    endcase
  endfunction

  function automatic logic [15:0] cfg_ib(input int g);
    case (g)
      1: return 16'hFFFE;
      2: return 16'h0200;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] cfg_ob(input int g);
    case (g)
      1: return 16'h8100;
      2: return 16'h8200;
      3: return 16'd100;
      default: return 16'h8000;
    endcase
  endfunction

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] addr;
    logic [7:0]  data;
  } acc_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NI-1:0] start_v, busy_v, end_v, en_r_v, en_v, wea_v;
  state_t        state_v  [NI];
  logic [15:0]   addr_r_v [NI];
  logic [15:0]   addr_w_v [NI];
  logic [7:0]    data_w_v [NI];
  logic [7:0]    mem [0:65535];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    maxpool_engine_if bus ();
    maxpool_engine #(
      .IN_W(cfg_w(g)), .IN_H(cfg_w(g)), .CH(cfg_ch(g)),
      .IN_BASE(cfg_ib(g)), .OUT_BASE(cfg_ob(g))
    ) dut (
      .clk(clk), .rst(rst), .start(start_v[g]), .ram(bus),
      .busy(busy_v[g]), .end_flag(end_v[g]), .dbg_state(state_v[g])
    );
    assign addr_r_v[g] = bus.ram_addr_r;
    assign en_r_v[g]   = bus.ram_en_r;
    assign addr_w_v[g] = bus.ram_addr_w;
    assign data_w_v[g] = bus.ram_data_w;
    assign en_v[g]     = bus.ram_en;
    assign wea_v[g]    = bus.ram_wea;
    // synchronous RAM read port with one cycle of latency
    always @(posedge clk) if (bus.ram_en_r) bus.ram_data_r <= mem[bus.ram_addr_r];
  end

  // ---------------- bus monitor ----------------
  acc_t wr_log[$];
  acc_t rd_log[$];
  acc_t mon_e;
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (en_v[k] && wea_v[k]) begin
        mon_e.id = 3'(k); mon_e.addr = addr_w_v[k]; mon_e.data = data_w_v[k];
        wr_log.push_back(mon_e);
      end
      if (en_r_v[k]) begin
        mon_e.id = 3'(k); mon_e.addr = addr_r_v[k]; mon_e.data = 8'h00;
        rd_log.push_back(mon_e);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_d_q[$];
  int last_wbase, last_rbase;

  function automatic logic [15:0] in_addr(input int id, input int c, input int y, input int x);
    return 16'(int'(cfg_ib(id)) + c * cfg_w(id) * cfg_w(id) + y * cfg_w(id) + x);
  endfunction

  // Reference: for every output pixel take the signed max of its 2x2 window.
  task automatic model_pass(input int id);
    int w, ow, oh;
    logic [7:0] m, v;
    w  = cfg_w(id);
    ow = w / 2;
    oh = w / 2;
    exp_q.delete();
    exp_d_q.delete();
    for (int c = 0; c < cfg_ch(id); c++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          m = mem[in_addr(id, c, 2 * oy, 2 * ox)];
          for (int q = 1; q < 4; q++) begin
            v = mem[in_addr(id, c, 2 * oy + q / 2, 2 * ox + q % 2)];
            if ($signed(v) > $signed(m)) m = v;
          end
          exp_q.push_back(16'(int'(cfg_ob(id)) + c * oh * ow + oy * ow + ox));
          exp_d_q.push_back(m);
        end
  endtask

  task automatic fill_random(input int id);
    for (int c = 0; c < cfg_ch(id); c++)
      for (int y = 0; y < cfg_w(id); y++)
        for (int x = 0; x < cfg_w(id); x++)
          mem[in_addr(id, c, y, x)] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- driver: one complete pass ----------------
  task automatic run_pass(input int id, input int restart_at);
    int n_pix, limit, cyc, wbase, rbase;
    bit got_end, busy_bad;
    n_pix = cfg_ch(id) * (cfg_w(id) / 2) * (cfg_w(id) / 2);
    model_pass(id);
    wbase = wr_log.size();
    rbase = rd_log.size();
    last_wbase = wbase;
    last_rbase = rbase;
    limit = 6 * n_pix + 20;
    @(posedge clk); #1; start_v[id] = 1'b1;
    @(posedge clk); #1; start_v[id] = 1'b0;
    cyc = 1; got_end = 0; busy_bad = 0;
    while (cyc <= limit && !got_end) begin
      if (!busy_v[id]) busy_bad = 1;
      if (end_v[id]) got_end = 1;
      else begin
        if (cyc == restart_at) start_v[id] = 1'b1;
        @(posedge clk); #1; start_v[id] = 1'b0;
        cyc++;
      end
    end
    n_checks++;
    if (!got_end || cyc != 6 * n_pix + 1) begin
      n_fail++;
      $display("FAIL end_cycle inst%0d: got cycle %0d (seen=%0d), expected %0d", id, cyc, got_end, 6 * n_pix + 1);
    end
    n_checks++;
    if (busy_bad) begin
      n_fail++;
      $display("FAIL busy_window inst%0d: busy dropped before end_flag, expected high", id);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({end_v[id], busy_v[id], en_r_v[id], en_v[id], wea_v[id]} !== 5'b0) begin
      n_fail++;
      $display("FAIL after_end inst%0d: end/busy/en_r/en/wea=%b, expected 00000", id,
               {end_v[id], busy_v[id], en_r_v[id], en_v[id], wea_v[id]});
    end
    n_checks++;
    if (wr_log.size() - wbase != exp_q.size()) begin
      n_fail++;
      $display("FAIL write_count inst%0d: got %0d, expected %0d", id, wr_log.size() - wbase, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && wbase + i < wr_log.size(); i++) begin
      n_checks++;
      if (wr_log[wbase + i] !== {3'(id), exp_q[i], exp_d_q[i]}) begin
        n_fail++;
        $display("FAIL write inst%0d #%0d: got id%0d @%h=%h, expected id%0d @%h=%h", id, i,
                 wr_log[wbase + i].id, wr_log[wbase + i].addr, wr_log[wbase + i].data, id, exp_q[i], exp_d_q[i]);
      end
    end
    n_checks++;
    if (rd_log.size() - rbase != 4 * n_pix) begin
      n_fail++;
      $display("FAIL read_count inst%0d: got %0d, expected %0d", id, rd_log.size() - rbase, 4 * n_pix);
    end
    n_checks++;
    if ({addr_w_v[id], data_w_v[id]} !== {exp_q[exp_q.size() - 1], exp_d_q[exp_d_q.size() - 1]}) begin
      n_fail++;
      $display("FAIL hold_last inst%0d: got @%h=%h, expected @%h=%h", id, addr_w_v[id], data_w_v[id],
               exp_q[exp_q.size() - 1], exp_d_q[exp_d_q.size() - 1]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({addr_r_v[k], en_r_v[k], addr_w_v[k], data_w_v[k], en_v[k], wea_v[k], busy_v[k], end_v[k]} !== 45'b0
          || state_v[k] !== S_IDLE) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: ar=%h er=%b aw=%h dw=%h en=%b we=%b busy=%b end=%b st=%0d, expected all 0 / IDLE",
                 k, addr_r_v[k], en_r_v[k], addr_w_v[k], data_w_v[k], en_v[k], wea_v[k], busy_v[k], end_v[k], state_v[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed_4x4();
    logic [7:0] want [4];
    want = '{8'd6, 8'd8, 8'd14, 8'd16};
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    run_pass(0, 0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (last_wbase + i >= wr_log.size() ||
          {wr_log[last_wbase + i].addr, wr_log[last_wbase + i].data} !== {16'(16'h8000 + i), want[i]}) begin
        n_fail++;
        $display("FAIL directed_4x4 #%0d: got @%h=%0d, expected @%h=%0d", i,
                 (last_wbase + i < wr_log.size()) ? wr_log[last_wbase + i].addr : 16'hxxxx,
                 (last_wbase + i < wr_log.size()) ? wr_log[last_wbase + i].data : 8'hxx,
                 16'(16'h8000 + i), want[i]);
      end
    end
  endtask

  task automatic test_negative_2x2();
    for (int p = 0; p < 4; p++) begin
      for (int q = 0; q < 4; q++) mem[16'(16'hFFFE + q)] = 8'h80;
      mem[16'(16'hFFFE + p)] = 8'h81;
      run_pass(1, 0);
      n_checks++;
      if (last_wbase >= wr_log.size() || wr_log[last_wbase].data !== 8'h81) begin
        n_fail++;
        $display("FAIL neg_single pos%0d: got %h, expected 81", p,
                 (last_wbase < wr_log.size()) ? wr_log[last_wbase].data : 8'hxx);
      end
    end
    mem[16'hFFFE] = 8'hFB; mem[16'hFFFF] = 8'hFD; mem[16'h0000] = 8'hF9; mem[16'h0001] = 8'hF7;
    run_pass(1, 0);
    n_checks++;
    if (last_wbase >= wr_log.size() || wr_log[last_wbase].data !== 8'hFD) begin
      n_fail++;
      $display("FAIL neg_mixed: got %h, expected fd",
               (last_wbase < wr_log.size()) ? wr_log[last_wbase].data : 8'hxx);
    end
    fill_random(1);
    run_pass(1, 0);
  endtask

  task automatic test_odd_size();
    int bad, off;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        mem[in_addr(2, 0, y, x)] = (x == 4 || y == 4) ? 8'h7F : 8'($urandom_range(0, 200));
    run_pass(2, 0);
    bad = 0;
    for (int i = last_rbase; i < rd_log.size(); i++) begin
      off = int'(rd_log[i].addr) - 'h200;
      if (off % 5 == 4 || off / 5 == 4) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL odd_edge_reads: got %0d reads of column/row 4, expected 0", bad);
    end
  endtask

  task automatic test_two_channel();
    fill_random(3);
    run_pass(3, 0);
    n_checks++;
    if (last_rbase + 16 >= rd_log.size() || rd_log[last_rbase + 16].addr !== 16'd16) begin
      n_fail++;
      $display("FAIL ch1_first_read: got %0d, expected 16",
               (last_rbase + 16 < rd_log.size()) ? rd_log[last_rbase + 16].addr : 16'hxxxx);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (last_wbase + 4 + i >= wr_log.size() || wr_log[last_wbase + 4 + i].addr !== 16'(104 + i)) begin
        n_fail++;
        $display("FAIL ch1_write_addr #%0d: got %0d, expected %0d", i,
                 (last_wbase + 4 + i < wr_log.size()) ? wr_log[last_wbase + 4 + i].addr : 16'hxxxx, 104 + i);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill_random(0);
      run_pass(0, 0);
      fill_random(2);
      run_pass(2, 0);
    end
    fill_random(4);
    run_pass(4, 0);
  endtask

  task automatic test_back_to_back();
    fill_random(0);
    run_pass(0, 0);
    fill_random(0);
    run_pass(0, 0);
  endtask

  task automatic test_start_while_busy();
    fill_random(0);
    run_pass(0, 7);
    fill_random(0);
    run_pass(0, 24);
  endtask

  task automatic test_reset_mid_pass();
    int cyc, rb, wb;
    bit saw_end;
    fill_random(0);
    @(posedge clk); #1; start_v[0] = 1'b1;
    @(posedge clk); #1; start_v[0] = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({en_r_v[0], en_v[0], wea_v[0], end_v[0], busy_v[0]} !== 5'b0 || state_v[0] !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_abort: en_r/en/wea/end/busy=%b st=%0d, expected 00000 / IDLE",
               {en_r_v[0], en_v[0], wea_v[0], end_v[0], busy_v[0]}, state_v[0]);
    end
    rst = 1'b0;
    rb = rd_log.size();
    wb = wr_log.size();
    saw_end = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (end_v[0]) saw_end = 1;
    end
    n_checks++;
    if (saw_end || rd_log.size() != rb || wr_log.size() != wb) begin
      n_fail++;
      $display("FAIL reset_quiet: end=%0d reads=%0d writes=%0d, expected 0 0 0", saw_end,
               rd_log.size() - rb, wr_log.size() - wb);
    end
    run_pass(0, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    start_v = '0;
    test_reset();
    test_directed_4x4();
    test_negative_2x2();
    test_odd_size();
    test_two_channel();
    test_random();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maxpool_engine.md
MAXPOOL_ENGINE -- requirements
Module: maxpool_engine

Interface
REQ-001 The block SHALL have parameter IN_W, default 28: input feature-map width in pixels, 2..255.
REQ-002 The block SHALL have parameter IN_H, default 28: input feature-map height in pixels, 2..255.
REQ-003 The block SHALL have parameter CH, default 6: channel count, 1..64.
REQ-004 The block SHALL have parameter IN_BASE, default 16'h0000: RAM base address of the input map.
REQ-005 The block SHALL have parameter OUT_BASE, default 16'h8000: RAM base address of the output map.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse that begins a pooling pass.
REQ-010 ram_addr_r  out  16  read address.
REQ-011 ram_en_r  out  1  read enable.
REQ-012 ram_data_r  in  8  signed int8 read data, valid exactly one cycle after ram_en_r.
REQ-013 ram_addr_w  out  16  write address.
REQ-014 ram_data_w  out  8  write data.
REQ-015 ram_en  out  1  write-port enable.
REQ-016 ram_wea  out  1  write strobe.
REQ-017 busy  out  1  high from the cycle after start until end_flag inclusive.
REQ-018 end_flag  out  1  one-cycle completion pulse; drives the memory mux's end_MP input.

Function
REQ-019 Layout SHALL be channel-major row-major: addr = BASE + c*H*W + y*W + x, computed modulo 2^16.
REQ-020 Output dimensions SHALL be OW = floor(IN_W/2) and OH = floor(IN_H/2); an odd last column or row is ignored.
REQ-021 The FSM SHALL have the states IDLE, RD0, RD1, RD2, RD3, WAIT, WR, DONE.
REQ-022 IDLE -> RD0 on start; all other states SHALL ignore start.
REQ-023 RD0..RD3 SHALL assert ram_en_r with the addresses of (2ox,2oy), (2ox+1,2oy), (2ox,2oy+1), (2ox+1,2oy+1) respectively.
REQ-024 Data for RD0 SHALL load the running max in RD1; data arriving in RD2, RD3 and WAIT SHALL be compared as signed and the larger value kept.
REQ-025 WR SHALL assert ram_en=ram_wea=1, with ram_data_w = max and ram_addr_w = OUT_BASE + c*OH*OW + oy*OW + ox.
REQ-026 After WR, the counters SHALL advance ox, then oy, then c; if more output pixels remain the FSM goes to RD0, otherwise to DONE.
REQ-027 DONE SHALL pulse end_flag for one cycle and then return to IDLE.
REQ-028 Throughput SHALL be exactly 6 cycles per output pixel; end_flag SHALL assert 6*CH*OH*OW+1 cycles after the start cycle.
REQ-029 Outside its active states each strobe (ram_en_r, ram_en, ram_wea, end_flag) SHALL be 0; addresses and data SHALL hold their last value.
REQ-030 Ties SHALL keep the earlier value; the bit result is identical either way.

Reset
REQ-031 Reset SHALL force IDLE and set every output to 0 and every counter and the running max to 0.
REQ-032 Reset mid-pass SHALL abort the pass with no further read or write and no end_flag; a later start SHALL restart from c=oy=ox=0.
REQ-033 Reset SHALL take priority over start in the same cycle.

Structure
REQ-034 The shared package cnn_pkg SHALL hold ADDR_W=16, DATA_W=8 and the FSM state encoding.
REQ-035 One sub-module, mp_addr_gen, SHALL hold the ox/oy/c counters and the read and write address arithmetic; the comparator and FSM stay in maxpool_engine.

Verification
REQ-036 4x4x1 input 1..16 row-major, start -> writes OUT_BASE..+3 = 6, 8, 14, 16; end_flag at cycle 25 after start.
REQ-037 2x2x1 input all -128 except one -127 -> single write of -127 (8'h81); negative values all -5, -3, -7, -9 -> write -3.
REQ-038 5x5x1 input -> exactly 4 writes; no read touches column 4 or row 4.
REQ-039 4x4x2, IN_BASE=0, OUT_BASE=100 -> channel-1 writes go to addresses 104..107, with reads starting at address 16.
REQ-040 start re-pulsed while busy -> ignored, and the cycle count is unchanged; rst asserted in cycle 10 -> all strobes 0 next cycle and no end_flag; a new start completes normally.
